// File: rtl/bus_xfer_sched_if.sv
// Request/response and reg_op bundle between the control unit, the bus
// transfer scheduler and the bus-attached registers.
interface bus_xfer_sched_if #(
  parameter int unsigned N_REG = 4,
  parameter int unsigned N_REQ = 2
);
  localparam int unsigned IW = $clog2(N_REG);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*IW-1:0] req_src;
  logic [N_REQ*IW-1:0] req_dst;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic [N_REG*2-1:0]  reg_op;
  logic                busy;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, done, err, reg_op, busy
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, done, err, reg_op, busy
  );
endinterface

// File: rtl/bus_xfer_sched.sv
// Round-robin scheduler for register-to-register moves on the shared 8-bit
// bus: one ENABLE source and one LOAD destination per three-cycle transfer.
module bus_xfer_sched #(
  parameter int unsigned N_REG = 4,
  parameter int unsigned N_REQ = 2
) (
  input  logic               clock,
  input  logic               reset,
  bus_xfer_sched_if.slave    bus
);
  localparam int unsigned IW = $clog2(N_REG);
  localparam int unsigned RW = $clog2(N_REQ);

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_ENABLE = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [RW-1:0]      rr, rr_nxt;
  logic [RW-1:0]      gnt_q, gnt_nxt;
  logic [IW-1:0]      src_q, src_nxt;
  logic [IW-1:0]      dst_q, dst_nxt;
  logic [N_REG*2-1:0] reg_op_q, reg_op_nxt;
  logic [N_REQ-1:0]   done_q, done_nxt;
  logic [N_REQ-1:0]   err_q, err_nxt;
  logic               busy_q, busy_nxt;

  logic [N_REQ-1:0]   ready_c;
  logic               found_c;
  logic [RW-1:0]      pick_c;
  logic [RW:0]        scan_c;
  logic [IW-1:0]      sel_src_c;
  logic [IW-1:0]      sel_dst_c;
  logic               legal_c;

  // First valid requester at or after rr, wrapping
  always_comb begin
    found_c = 1'b0;
    pick_c  = rr;
    scan_c  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_c = (RW+1)'(rr) + (RW+1)'(i);
      if (scan_c >= (RW+1)'(N_REQ)) scan_c = scan_c - (RW+1)'(N_REQ);
      if (!found_c && bus.req_valid[scan_c[RW-1:0]]) begin
        found_c = 1'b1;
        pick_c  = scan_c[RW-1:0];
      end
    end
  end

  assign sel_src_c = bus.req_src[pick_c*IW +: IW];
  assign sel_dst_c = bus.req_dst[pick_c*IW +: IW];
  assign legal_c   = (sel_src_c != sel_dst_c) &&
                     ((IW+1)'(sel_src_c) < (IW+1)'(N_REG)) &&
                     ((IW+1)'(sel_dst_c) < (IW+1)'(N_REG));

  // Next state, grant and latched transfer fields
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    gnt_nxt   = gnt_q;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    ready_c   = '0;
    case (state)
      S_IDLE: begin
        if (found_c && reset) begin
          ready_c[pick_c] = 1'b1;
          gnt_nxt         = pick_c;
          src_nxt         = sel_src_c;
          dst_nxt         = sel_dst_c;
          state_nxt       = legal_c ? S_XFER : S_ERR;
        end
      end
      S_XFER: state_nxt = S_DONE;
      S_DONE, S_ERR: begin
        state_nxt = S_IDLE;
        rr_nxt    = (gnt_q == RW'(N_REQ - 1)) ? '0 : gnt_q + RW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they leave the chip registered
  always_comb begin
    reg_op_nxt = '0;
    done_nxt   = '0;
    err_nxt    = '0;
    busy_nxt   = (state_nxt != S_IDLE);
    if (state_nxt == S_XFER) begin
      for (int unsigned r = 0; r < N_REG; r++) begin
        if (src_nxt == IW'(r))      reg_op_nxt[2*r +: 2] = OP_ENABLE;
        else if (dst_nxt == IW'(r)) reg_op_nxt[2*r +: 2] = OP_LOAD;
        else                        reg_op_nxt[2*r +: 2] = OP_NOP;
      end
    end
    if (state_nxt == S_DONE) done_nxt[gnt_nxt] = 1'b1;
    if (state_nxt == S_ERR)  err_nxt[gnt_nxt]  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rr       <= '0;
      gnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      reg_op_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr       <= rr_nxt;
      gnt_q    <= gnt_nxt;
      src_q    <= src_nxt;
      dst_q    <= dst_nxt;
      reg_op_q <= reg_op_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.reg_op    = reg_op_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bus_xfer_sched.sv
// Directed bench for bus_xfer_sched: a cycle-timeline model of grants plus a
// toy register file driven by reg_op, with literal spot checks.
module tb_bus_xfer_sched;
  localparam int unsigned NR    = 4;
  localparam int unsigned NQ    = 2;
  localparam int unsigned IW    = 2;
  localparam int unsigned DEPTH = 512;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int unsigned cyc = 0;

  // Expected outputs per cycle, filled in when the model grants
  logic [NQ-1:0]   e_ready [DEPTH];
  logic [NQ-1:0]   e_done  [DEPTH];
  logic [NQ-1:0]   e_err   [DEPTH];
  logic [2*NR-1:0] e_op    [DEPTH];
  logic            e_busy  [DEPTH];
  int              m_rr = 0;
  int unsigned     m_free = 0;
  logic [7:0]      regs [NR];

  bus_xfer_sched_if #(.N_REG(NR), .N_REQ(NQ)) bus ();

  bus_xfer_sched #(.N_REG(NR), .N_REQ(NQ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus registers: ENABLE drives, LOAD captures at the negedge
  always @(negedge clock) begin
    int en, ld;
    en = -1;
    ld = -1;
    for (int r = 0; r < NR; r++) begin
      if (bus.reg_op[2*r +: 2] == 2'd2) en = r;
      if (bus.reg_op[2*r +: 2] == 2'd1) ld = r;
    end
    if (en >= 0 && ld >= 0) regs[ld] = regs[en];
  end

  // Timeline model and per-cycle compare
  always @(negedge clock) begin
    int unsigned c;
    int g, s, d, n_en, n_ld;
    logic [2*NR-1:0] v;
    c = cyc;
    g = -1;
    if (!reset) begin
      for (int j = 0; j < 4; j++) begin
        if (c + j < DEPTH) begin
          e_ready[c+j] = '0; e_done[c+j] = '0; e_err[c+j] = '0;
          e_op[c+j] = '0;    e_busy[c+j] = 1'b0;
        end
      end
      m_rr   = 0;
      m_free = 0;
    end else if (c >= m_free && bus.req_valid != '0 && c + 3 < DEPTH) begin
      for (int i = 0; i < NQ; i++) begin
        int k;
        k = (m_rr + i) % NQ;
        if (g < 0 && bus.req_valid[k]) g = k;
      end
      s = int'(bus.req_src[g*IW +: IW]);
      d = int'(bus.req_dst[g*IW +: IW]);
      e_ready[c] = NQ'(1 << g);
      m_rr = (g + 1) % NQ;
      if (s != d && s < NR && d < NR) begin
        v = '0;
        v[2*s +: 2] = 2'd2;
        v[2*d +: 2] = 2'd1;
        e_op[c+1]   = v;
        e_busy[c+1] = 1'b1;
        e_busy[c+2] = 1'b1;
        e_done[c+2] = NQ'(1 << g);
        m_free = c + 3;
      end else begin
        e_err[c+1]  = NQ'(1 << g);
        e_busy[c+1] = 1'b1;
        m_free = c + 2;
      end
    end
    if (c < DEPTH) begin
      check("ready", 32'(bus.req_ready), 32'(e_ready[c]));
      check("reg_op", 32'(bus.reg_op), 32'(e_op[c]));
      check("done", 32'(bus.done), 32'(e_done[c]));
      check("err", 32'(bus.err), 32'(e_err[c]));
      check("busy", 32'(bus.busy), 32'(e_busy[c]));
    end
    n_en = 0;
    n_ld = 0;
    for (int r = 0; r < NR; r++) begin
      if (bus.reg_op[2*r +: 2] == 2'd2) n_en++;
      if (bus.reg_op[2*r +: 2] == 2'd1) n_ld++;
    end
    check("one_enable", 32'(n_en <= 1), 32'(1));
    check("one_load", 32'(n_ld <= 1), 32'(1));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      e_ready[i] = '0; e_done[i] = '0; e_err[i] = '0; e_op[i] = '0; e_busy[i] = 1'b0;
    end
    regs[0] = 8'h10; regs[1] = 8'h21; regs[2] = 8'h32; regs[3] = 8'h43;
    // req1: 0->2, req0: 1->3
    bus.req_valid = 2'b11;
    bus.req_src   = {2'd0, 2'd1};
    bus.req_dst   = {2'd2, 2'd3};

    // Reset held with both requesters valid
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    check("rst_op", 32'(bus.reg_op), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock); check("first_grant", 32'(bus.req_ready), 32'(2'b01));
    @(posedge clock); #1; bus.req_valid = 2'b10;
    @(negedge clock); check("xfer_op", 32'(bus.reg_op), 32'(8'h48));
    check("xfer_busy", 32'(bus.busy), 32'(1));
    @(posedge clock); #1;
    @(negedge clock); check("done0", 32'(bus.done), 32'(2'b01));
    @(posedge clock); #1;
    @(negedge clock); check("idle_busy", 32'(bus.busy), 32'(0));
    check("second_grant", 32'(bus.req_ready), 32'(2'b10));
    @(posedge clock); #1; bus.req_valid = 2'b00;
    check("reg3_data", 32'(regs[3]), 32'(8'h21));
    @(negedge clock); check("xfer1_op", 32'(bus.reg_op), 32'(8'h12));
    @(posedge clock); #1;
    @(negedge clock); check("done1", 32'(bus.done), 32'(2'b10));
    @(posedge clock); #1;
    check("reg2_data", 32'(regs[2]), 32'(8'h10));

    // Round-robin with both requesters held
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rr_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      if (k < 3) repeat (2) @(negedge clock);
    end
    @(posedge clock); #1; bus.req_valid = 2'b00;
    repeat (3) @(posedge clock); #1;

    // Illegal src==dst from requester 1, then requester 0 legal
    bus.req_valid = 2'b10;
    bus.req_src   = {2'd2, 2'd3};
    bus.req_dst   = {2'd2, 2'd0};
    @(negedge clock); check("ill_accept", 32'(bus.req_ready), 32'(2'b10));
    @(posedge clock); #1; bus.req_valid = 2'b01;
    @(negedge clock); check("ill_err", 32'(bus.err), 32'(2'b10));
    check("ill_op", 32'(bus.reg_op), 32'(0));
    @(posedge clock); #1;
    @(negedge clock); check("ill_next", 32'(bus.req_ready), 32'(2'b01));
    @(posedge clock); #1; bus.req_valid = 2'b00;
    repeat (2) @(posedge clock); #1;

    // Source changes after acceptance must not affect the transfer
    bus.req_valid = 2'b10;
    bus.req_src   = {2'd3, 2'd3};
    bus.req_dst   = {2'd1, 2'd0};
    @(negedge clock); check("chg_accept", 32'(bus.req_ready), 32'(2'b10));
    @(posedge clock); #1; bus.req_valid = 2'b00; bus.req_src = {2'd0, 2'd3};
    @(negedge clock); check("chg_op", 32'(bus.reg_op), 32'(8'h84));
    repeat (2) @(posedge clock); #1;

    // Advance rr to 1 with a full requester-0 transfer
    bus.req_valid = 2'b01;
    bus.req_src   = {2'd3, 2'd2};
    bus.req_dst   = {2'd1, 2'd1};
    @(negedge clock); check("pre_accept", 32'(bus.req_ready), 32'(2'b01));
    @(posedge clock); #1; bus.req_valid = 2'b00;
    repeat (2) @(posedge clock); #1;

    // Reset asserted mid-XFER of requester 1
    bus.req_valid = 2'b10;
    bus.req_src   = {2'd2, 2'd2};
    bus.req_dst   = {2'd0, 2'd1};
    @(negedge clock); check("mid_accept", 32'(bus.req_ready), 32'(2'b10));
    @(posedge clock); #1; bus.req_valid = 2'b00;
    check("mid_op", 32'(bus.reg_op), 32'(8'h21));
    #1; reset = 1'b0;
    #1; check("mid_op_nop", 32'(bus.reg_op), 32'(0));
    check("mid_busy", 32'(bus.busy), 32'(0));
    @(posedge clock); #1;
    @(negedge clock); check("mid_no_done", 32'(bus.done), 32'(0));
    @(posedge clock); #1; reset = 1'b1; bus.req_valid = 2'b11;
    @(negedge clock); check("rr_after_reset", 32'(bus.req_ready), 32'(2'b01));
    @(posedge clock); #1; bus.req_valid = 2'b00;
    repeat (4) @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_xfer_sched.md
# bus_xfer_sched

Bus transfer scheduler for the shared 8-bit data bus of the register file. It arbitrates register-to-register move requests from several requesters, such as the instruction decoder and the interrupt or debug path. It drives each bus register's `reg_op_e` so that exactly one register drives the bus (ENABLE) and exactly one captures it (LOAD) per transfer. It sits between the control unit and the `reg_op` inputs of every bus-attached register.

## Interface
Parameters:
- `N_REG`, default 4: number of bus-attached registers (2..8); index width `IW = $clog2(N_REG)`.
- `N_REQ`, default 2: number of requesters (2..4).

Ports:
- `clock`  in  1  : single clock; all state changes on posedge.
- `reset`  in  1  : asynchronous, active-low (0 = in reset).
- `req_valid`  in  N_REQ  : requester k holds a transfer request while bit k = 1.
- `req_src`  in  N_REQ*IW  : packed; slice k is the register index to drive the bus.
- `req_dst`  in  N_REQ*IW  : packed; slice k is the register index to load from the bus.
- `req_ready`  out  N_REQ  : one-hot accept; request k is consumed in the cycle `req_valid[k] & req_ready[k]`.
- `done`  out  N_REQ  : one-cycle pulse after requester k's transfer completes.
- `err`  out  N_REQ  : one-cycle pulse; requester k's accepted request was rejected.
- `reg_op`  out  N_REG*2  : packed `reg_op_e` per register; NOP=2'd0, LOAD=2'd1, ENABLE=2'd2.
- `busy`  out  1  : 1 in any state other than IDLE.

## Operation
- FSM states: IDLE, XFER, DONE, ERR.
- **IDLE**
  - If any `req_valid`, grant the first valid requester at or after the round-robin pointer `rr`, searching upward and wrapping.
  - `req_ready[g]=1` (combinational, same cycle); latch `g`, src and dst.
  - If `src==dst`, `src>=N_REG` or `dst>=N_REG`: next state ERR. Otherwise: next state XFER.
- **XFER** (exactly one cycle)
  - `reg_op[src]=ENABLE`, `reg_op[dst]=LOAD`, all others NOP.
  - Next state DONE.
- **DONE**
  - All `reg_op`=NOP; `done[g]=1`; `rr <= g+1` (mod N_REQ).
  - Next state IDLE.
- **ERR**
  - All `reg_op`=NOP; `err[g]=1`; `rr <= g+1` (mod N_REQ).
  - Next state IDLE.
- `req_ready` is 0 in every state except IDLE; at most one bit is set.
- Requests not granted remain pending; requesters must hold `req_valid`, `req_src` and `req_dst` stable until ready.
- Changes on `req_src`/`req_dst` after acceptance have no effect on the transfer in flight.
- `reg_op`, `done`, `err` and `busy` are decoded from registered state and latched fields only, never from request inputs.
- Invariant, every cycle: at most one register at ENABLE and at most one at LOAD.

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE, `rr`=0, all `reg_op`=NOP, `done`=0, `err`=0, `busy`=0.
  - `req_ready`=0 while reset is asserted.
- Reset asserted mid-XFER: ops return to NOP immediately; no `done` pulse is produced.
- Accept at cycle T (IDLE): XFER in T+1, DONE in T+2, IDLE in T+3.
  - Earliest next accept is T+3, so throughput is 1 transfer per 3 cycles.
- Bus register behaviour under XFER: ENABLE drives at the posedge of T+1; LOAD captures at the negedge of T+1.
  - Data is therefore valid in `dst` before the posedge of T+2.
- Error path: accept at T, `err` pulse at T+1, IDLE at T+2.
- `busy` is 1 from T+1 through the cycle before the return to IDLE.
- Simultaneous requests: only one grant per IDLE cycle; a loser is granted at the next IDLE, because `rr` moved past the winner.
- Pointer wrap: `rr`=N_REQ-1 with that requester granted sets `rr` to 0.

## Test plan
- **Reset values:** hold `reset`=0 with `req_valid`=2'b11 -> `req_ready`=0, all `reg_op`=0, `busy`=0; release -> grant requester 0 in the first IDLE cycle.
- **Single transfer:** requester 0 asks src=1, dst=3 -> `req_ready`=2'b01 at T; `reg_op`={NOP,ENABLE,NOP,LOAD}(reg3..0 = LOAD,NOP,ENABLE,NOP) at T+1; `done`=2'b01 at T+2; `busy`=0 at T+3. Register 3 holds register 1's value.
- **Round-robin:** both requesters valid continuously -> grants alternate 0,1,0,1 at T, T+3, T+6, T+9; no ENABLE/LOAD overlap in any cycle.
- **Illegal request:** requester 1 asks src=2, dst=2 -> accepted at T; `err`=2'b10 at T+1; `reg_op` all NOP throughout; next grant at T+2.
- **Reset mid-operation:** assert `reset`=0 during XFER -> `reg_op` goes to NOP asynchronously; no `done`; after release, `rr`=0.
- **Input change after accept:** change `req_src` at T+1 -> the XFER still uses the latched src.
